// File: rtl/code_word_rx.sv
// code_word_rx
// Serial receiver feeding the 2-out-of-5 decoder. It samples an asynchronous
// serial line and assembles a 5-bit code word from each frame. A frame is a
// start bit (0), five data bits sent MSB first, and a stop bit (1). Whether the
// word is a valid code word (exactly two ones) is checked further downstream.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   sdi       serial data line, asynchronous to clk, idles high
//   a..e      last good code word, a = first data bit received (MSB)
//   new_word  one-cycle pulse when a..e take a new word ("new" is a reserved
//             word in SystemVerilog, so the port carries this name)
//   ferr      framing error flag; set on a bad stop bit, cleared by the next
//             good frame, held through IDLE
//   busy      high whenever the receiver is not in IDLE
//
// Parameter CLKS_PER_BIT (N) must be even and >= 4. Sampling happens H = N/2
// cycles into the start bit, then every N cycles.
//
// state  | meaning
// IDLE   | line idle, waiting for sync low
// START  | timing half a bit to the middle of the start bit
// DATA   | sampling five data bits, one per bit period
// STOP   | timing to the middle of the stop bit
// BREAK  | stop bit was low; wait for the line to return high

module code_word_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sdi,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic new_word,
   output logic ferr,
   output logic busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic [1:0]    sync_q;
   logic          sync;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [4:0]    shreg;
   logic [4:0]    word;

   // Two-flop synchronizer; resets to the idle-high level so reset never
   // looks like a falling edge on a quiet line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], sdi};
      end
   end

   assign sync = sync_q[1];

   // The bit timer is a down-counter loaded with the remaining cycles to the
   // next sample point; a sample is taken when it reaches zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         word     <= '0;
         new_word <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         new_word <= 1'b0;
         case (state)
            IDLE: begin
               if (!sync) begin
                  state <= START;
                  cnt   <= CNT_HALF;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (!sync) begin
                     state   <= DATA;
                     cnt     <= CNT_BIT;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shreg <= {shreg[3:0], sync};
                  cnt   <= CNT_BIT;
                  if (bit_idx == 3'd4) begin
                     state   <= STOP;
                     bit_idx <= '0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  if (sync) begin
                     word     <= shreg;
                     new_word <= 1'b1;
                     ferr     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     ferr  <= 1'b1;
                     state <= BREAK;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            BREAK: begin
               // Held-low line must return high before a new start is armed.
               if (sync) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign {a, b, c, d, e} = word;
   assign busy = (state != IDLE);

endmodule
